// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen -- multi-channel clock-enable generator.
//
// Produces NUM_CH independent one-cycle tick pulses from clk. Each channel
// divides by N = max(divisor, 1). A new divisor captured with div_load is held
// pending and applied at the channel's next wrap, so a running period is never
// truncated. restart realigns every channel at once and applies any pending
// (or same-cycle) divisor immediately.
//
// Optional feature: define CLK_EN_GEN_LEVEL_EN to build the per-channel ~50%
// duty square wave on level. Without it level is tied low.
//
// Parameters:
//   NUM_CH      number of channels (1..8)
//   DIV_W       counter / divisor width
//   DEFAULT_DIV divisor loaded into every channel at reset
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   enable    in   global run enable; counters hold while low
//   restart   in   synchronous realign of all channels
//   div_i     in   new divisors, channel i in [i*DIV_W +: DIV_W]
//   div_load  in   per-channel capture strobe for div_i
//   tick      out  registered one-cycle enable pulse per channel
//   pending   out  high while a captured divisor awaits application
//   level     out  registered square wave per channel (feature build only)
// -----------------------------------------------------------------------------
module clk_en_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      restart,
    input  logic [NUM_CH*DIV_W-1:0]   div_i,
    input  logic [NUM_CH-1:0]         div_load,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         pending,
    output logic [NUM_CH-1:0]         level
);

    logic [DIV_W-1:0]  cnt       [NUM_CH];
    logic [DIV_W-1:0]  div_r     [NUM_CH];
    logic [DIV_W-1:0]  div_p     [NUM_CH];
    logic [NUM_CH-1:0] pend;

    logic [DIV_W-1:0]  cnt_nxt   [NUM_CH];
    logic [DIV_W-1:0]  div_r_nxt [NUM_CH];
    logic [DIV_W-1:0]  div_p_nxt [NUM_CH];
    logic [NUM_CH-1:0] pend_nxt;
    logic [NUM_CH-1:0] tick_nxt;

    // A programmed divisor of 0 runs as divide-by-1.
    function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    // Next-state logic for every channel.
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned -- that is what keeps this combinational, not a latch.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i]   = cnt[i];
            div_r_nxt[i] = div_r[i];
            div_p_nxt[i] = div_p[i];
            pend_nxt[i]  = pend[i];
            tick_nxt[i]  = 1'b0;

            if (div_load[i]) begin
                div_p_nxt[i] = div_i[i*DIV_W +: DIV_W];
            end

            if (restart) begin
                // Realign: a same-cycle load beats an older pending divisor.
                cnt_nxt[i]  = '0;
                pend_nxt[i] = 1'b0;
                if (div_load[i]) begin
                    div_r_nxt[i] = div_i[i*DIV_W +: DIV_W];
                end else if (pend[i]) begin
                    div_r_nxt[i] = div_p[i];
                end
            end else begin
                if (enable) begin
                    if (cnt[i] == eff_ratio(div_r[i]) - DIV_W'(1)) begin
                        cnt_nxt[i]  = '0;
                        tick_nxt[i] = 1'b1;
                        // Applies the divisor pending before this edge; a load
                        // arriving on this same edge waits for the next wrap.
                        if (pend[i]) begin
                            div_r_nxt[i] = div_p[i];
                            pend_nxt[i]  = 1'b0;
                        end
                    end else begin
                        cnt_nxt[i] = cnt[i] + DIV_W'(1);
                    end
                end
                if (div_load[i]) begin
                    pend_nxt[i] = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // The per-channel arrays are a handful of flops, so they all get reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= '0;
                div_r[i] <= DIV_W'(DEFAULT_DIV);
                div_p[i] <= '0;
            end
            pend <= '0;
            tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= cnt_nxt[i];
                div_r[i] <= div_r_nxt[i];
                div_p[i] <= div_p_nxt[i];
            end
            pend <= pend_nxt;
            tick <= tick_nxt;
        end
    end

    assign pending = pend;

`ifdef CLK_EN_GEN_LEVEL_EN
    logic [NUM_CH-1:0] level_nxt;
    logic [NUM_CH-1:0] level_r;

    // High for the upper half of the period, measured on the post-edge count
    // and the divisor that will be active after the edge.
    always_comb begin
        level_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            level_nxt[i] = (cnt_nxt[i] >= (eff_ratio(div_r_nxt[i]) >> 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r <= '0;
        end else if (restart) begin
            level_r <= '0;
        end else if (enable) begin
            level_r <= level_nxt;
        end
    end

    assign level = level_r;
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen -- self-checking bench for clk_en_gen (NUM_CH=2, DIV_W=8).
// A behavioural model tracks, per channel, how many enabled edges have elapsed
// in the current period, the active ratio and any pending divisor; a compare
// process checks tick/pending/level against it on every falling edge. Directed
// scenarios add literal expectations, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_clk_en_gen;

    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic                    clk;
    logic                    reset;
    logic                    enable;
    logic                    restart;
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic [NUM_CH-1:0]       div_load;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;
    logic [NUM_CH-1:0]       level;

    int checks = 0;
    int errors = 0;

    clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .restart  (restart),
        .div_i    (div_i),
        .div_load (div_load),
        .tick     (tick),
        .pending  (pending),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ph [NUM_CH];   // enabled edges elapsed in the current period
    int dr [NUM_CH];   // programmed active divisor
    int pv [NUM_CH];   // pending divisor value
    bit pd [NUM_CH];   // pending flag
    logic [NUM_CH-1:0] m_tick, m_lvl, m_pend;

    function automatic int ratio(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ph[i] = 0; dr[i] = DEFAULT_DIV; pv[i] = 0; pd[i] = 0;
            end
            m_tick = '0; m_lvl = '0; m_pend = '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int v;
                v = int'(div_i[i*DIV_W +: DIV_W]);
                m_tick[i] = 1'b0;
                if (restart) begin
                    if (div_load[i]) dr[i] = v;
                    else if (pd[i]) dr[i] = pv[i];
                    pd[i] = 0;
                    ph[i] = 0;
                    m_lvl[i] = 1'b0;
                end else begin
                    if (enable) begin
                        ph[i] = ph[i] + 1;
                        if (ph[i] == ratio(dr[i])) begin
                            m_tick[i] = 1'b1;
                            ph[i] = 0;
                            if (pd[i]) begin
                                dr[i] = pv[i];
                                pd[i] = 0;
                            end
                        end
                        m_lvl[i] = (ph[i] >= ratio(dr[i]) / 2);
                    end
                    if (div_load[i]) begin
                        pv[i] = v;
                        pd[i] = 1;
                    end
                end
                m_pend[i] = pd[i];
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        check("tick_model", 32'(tick), 32'(m_tick));
        check("pending_model", 32'(pending), 32'(m_pend));
`ifdef CLK_EN_GEN_LEVEL_EN
        check("level_model", 32'(level), 32'(m_lvl));
`else
        check("level_tied", 32'(level), 32'd0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_div(input int ch, input int v);
        div_i[ch*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; restart = 1'b0;
        div_i = '0; div_load = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        #2;
        reset = 1'b0;
        enable = 1'b1;

        // Defaults: both channels divide by 4.
        for (int k = 1; k <= 12; k++) begin
            next_edge();
            check("default_tick", 32'(tick), (k % 4 == 0) ? 32'd3 : 32'd0);
`ifdef CLK_EN_GEN_LEVEL_EN
            check("default_level", 32'(level), ((k % 4) >= 2) ? 32'd3 : 32'd0);
`endif
        end

        // Load 6 on ch0 while cnt=1: old period finishes, then spacing 6.
        next_edge();                         // edge 13, cnt=1
        set_div(0, 6); div_load = 2'b01;
        next_edge();                         // edge 14
        div_load = '0;
        check("load6_pending_rise", 32'(pending), 32'd1);
        next_edge();                         // edge 15
        check("load6_pending_hold", 32'(pending), 32'd1);
        next_edge();                         // edge 16: old-period wrap
        check("load6_old_wrap", 32'(tick[0]), 32'd1);
        check("load6_pending_fall", 32'(pending), 32'd0);
        for (int k = 17; k <= 28; k++) begin
            next_edge();
            check("load6_spacing", 32'(tick[0]), (k == 22 || k == 28) ? 32'd1 : 32'd0);
        end

        // Ch1 divisor 0 and ch0 divisor 4, applied by restart.
        set_div(0, 4); set_div(1, 0); div_load = 2'b11;
        next_edge();
        div_load = '0; restart = 1'b1;
        next_edge();                         // restart edge
        restart = 1'b0;
        check("restart_tick", 32'(tick), 32'd0);
        check("restart_pending", 32'(pending), 32'd0);
        next_edge();
        check("div0_tick_a", 32'(tick[1]), 32'd1);
        next_edge();                         // ch0 cnt=2
        check("div0_tick_b", 32'(tick[1]), 32'd1);

        // Enable low for 5 cycles with ch0 at cnt=2.
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_edge();
            check("disabled_tick", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        next_edge();
        check("reenable_tick_1", 32'(tick[0]), 32'd0);
        next_edge();
        check("reenable_tick_2", 32'(tick[0]), 32'd1);

        // Restart together with a load of 3 on ch0.
        set_div(0, 3); div_load = 2'b01; restart = 1'b1;
        next_edge();
        div_load = '0; restart = 1'b0;
        check("rl_pending", 32'(pending[0]), 32'd0);
        check("rl_tick0", 32'(tick[0]), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            next_edge();
            check("rl_spacing", 32'(tick[0]), (k % 3 == 0) ? 32'd1 : 32'd0);
        end

        // Async reset mid-count with a pending divisor and ch1 ticking.
        set_div(0, 7); div_load = 2'b01;
        next_edge();
        div_load = '0;
        check("pre_reset_pending", 32'(pending[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_tick", 32'(tick), 32'd0);
        check("async_pending", 32'(pending), 32'd0);
        check("async_level", 32'(level), 32'd0);
        #1 reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_edge();
            check("post_reset_tick", 32'(tick), (k % 4 == 0) ? 32'd3 : 32'd0);
        end

        // Randomized phase, checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            next_edge();
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                div_load[i] = ($urandom_range(0, 15) == 0);
                set_div(i, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                                       : int'($urandom_range(0, 9)));
            end
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #2 reset = 1'b0;
            end
        end
        next_edge();
        enable = 1'b0; restart = 1'b0; div_load = '0;
        repeat (2) next_edge();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
